regfile_decoded: RTL and testbench
==================================

Name: regfile_decoded

Overview:
- Parametrised register file: DEPTH words of WIDTH bits, one write port, two read ports.
- Write enables come from an internal one-hot write decoder (RegWrite shifted by WriteRegister). The decoded vector is also exported for debug and coverage.
- Successor to the fixed 32-way decoder and regfile pair. Adds:
  - async reset,
  - a selectable hardwired-zero register,
  - write-to-read bypass,
  - optional registered read outputs.
- Sits in the CPU datapath between the decode and execute stages.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- ADDR_BITS, 5, register address width; DEPTH = 2**ADDR_BITS (internal localparam).
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary storage.
- BYPASS, 1, 1 = a read of the register being written in the same cycle returns WriteData; 0 = it returns the stored (old) value.
- READ_LATENCY, 0, 0 = combinational reads; 1 = ReadData registered on posedge Clk. Other values are illegal: elaboration error via generate check.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- RegWrite  input  1  write request for this cycle.
- WriteRegister  input  ADDR_BITS  write address.
- WriteData  input  WIDTH  write data.
- ReadRegister1  input  ADDR_BITS  read port 1 address.
- ReadRegister2  input  ADDR_BITS  read port 2 address.
- ReadData1  output  WIDTH  read port 1 data.
- ReadData2  output  WIDTH  read port 2 data.
- WriteEnable  output  DEPTH  decoded one-hot write-enable vector (combinational).

Behaviour:
- Reset:
  - Reset_n low clears all DEPTH words to 0 immediately, independent of Clk.
  - READ_LATENCY=1: ReadData1/2 registers also clear to 0.
  - READ_LATENCY=0: ReadData follows the cleared array, so it reads 0.
  - WriteEnable stays combinational from the inputs during reset.
  - Writes are blocked while Reset_n is low.
  - A write edge coinciding with reset assertion is lost.
- Decoder:
  - WriteEnable = RegWrite ? (1 << WriteRegister) : 0, DEPTH bits wide.
  - Exactly one bit is set when RegWrite=1; all zero otherwise.
  - With ZERO_REG=1, bit 0 may still assert on the vector, but the storage write to word 0 is suppressed.
- Write:
  - On posedge Clk with Reset_n high and WriteEnable[k]=1, word k <= WriteData.
  - Write latency is 1 cycle; the value is visible to non-bypassed reads from the next cycle.
- Read, READ_LATENCY=0: ReadDataN = word[ReadRegisterN], combinational.
- Read, READ_LATENCY=1: on posedge, ReadDataN <= the value the latency-0 path would show in that cycle, bypass included. Data appears 1 cycle after the address.
- Zero register: with ZERO_REG=1, reads of address 0 return 0 in every mode, including when a write to 0 is in flight. Bypass never applies to address 0.
- Bypass (BYPASS=1):
  - Condition: RegWrite=1, ReadRegisterN==WriteRegister, and (ZERO_REG=0 or address!=0).
  - When met, the read path for port N selects WriteData instead of the stored word.
  - Both ports can bypass simultaneously.
- BYPASS=0: same-cycle read of the address being written returns the pre-write value.
- Both read ports may address the same word; no conflicts or stalls exist.
- Arithmetic: addresses are unsigned and every address value is legal, so there is no out-of-range case.
- Reset deasserted mid-cycle: the first write is accepted on the first posedge with Reset_n high.

Test Plan:
- Reset with defaults: Reset_n=0 after random writes -> every address reads 0; after release, write 0xDEADBEEF to r7, read r7 next cycle -> 0xDEADBEEF, WriteEnable = 0x00000080 during the write cycle.
- Zero register, ZERO_REG=1, BYPASS=1: write 0x12345678 to r0 -> WriteEnable=0x00000001, ReadData1(addr 0)=0 in the same cycle and all later cycles. With ZERO_REG=0, r0 reads 0x12345678 after the edge.
- Bypass: r3=0x11, then in one cycle RegWrite=1, WriteRegister=3, WriteData=0x22, ReadRegister1=ReadRegister2=3 -> BYPASS=1: both read 0x22 combinationally; BYPASS=0: both read 0x11, then 0x22 next cycle.
- Registered read, READ_LATENCY=1: address 5 (holding 0xA5) applied in cycle n -> ReadData1=0xA5 after posedge n, unchanged before it. Reset mid-stream -> ReadData1 drops to 0 immediately, without waiting for a clock edge.
- Width/depth generalisation, WIDTH=8, ADDR_BITS=3: write values k*17 to r1..r7 -> reads match; RegWrite=0 with WriteRegister=4 -> WriteEnable=0x00 and r4 unchanged.
- Decoder sweep: for all WriteRegister 0..DEPTH-1 with RegWrite=1 -> WriteEnable == 1<<addr, popcount 1; with RegWrite=0 -> WriteEnable == 0.

Source files
------------

// File: rtl/regfile_decoded.sv
// Register file with one write port and two read ports, writes steered by an
// internal one-hot decoder; optional zero register, write bypass and registered reads.
module regfile_decoded #(
  parameter int WIDTH        = 32,
  parameter int ADDR_BITS    = 5,
  parameter int ZERO_REG     = 1,
  parameter int BYPASS       = 1,
  parameter int READ_LATENCY = 0
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     RegWrite,
  input  logic [ADDR_BITS-1:0]     WriteRegister,
  input  logic [WIDTH-1:0]         WriteData,
  input  logic [ADDR_BITS-1:0]     ReadRegister1,
  input  logic [ADDR_BITS-1:0]     ReadRegister2,
  output logic [WIDTH-1:0]         ReadData1,
  output logic [WIDTH-1:0]         ReadData2,
  output logic [(1<<ADDR_BITS)-1:0] WriteEnable
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [DEPTH-1:0] ONE_HOT_0 = {{(DEPTH-1){1'b0}}, 1'b1};
  localparam logic [DEPTH-1:0] STORE_MASK = (ZERO_REG != 0) ? ~ONE_HOT_0 : '1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] store_en;
  logic [WIDTH-1:0] rd1_d;
  logic [WIDTH-1:0] rd2_d;

  assign WriteEnable = RegWrite ? (ONE_HOT_0 << WriteRegister) : '0;
  // Bit 0 may show on the debug vector, but word 0 never stores when hardwired.
  assign store_en    = WriteEnable & STORE_MASK;

  // NOTE: the array sits behind the async reset so every word reads 0 the
  // moment Reset_n drops; that rules out a RAM macro, which is intended here.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (store_en[k]) mem_q[k] <= WriteData;
      end
    end
  end

  function automatic logic [WIDTH-1:0] read_path(input logic [ADDR_BITS-1:0] addr);
    logic is_zero;
    logic is_byp;
    is_zero = (ZERO_REG != 0) && (addr == '0);
    is_byp  = (BYPASS != 0) && RegWrite && (addr == WriteRegister);
    if (is_zero)     return '0;
    else if (is_byp) return WriteData;
    else             return mem_q[addr];
  endfunction

  // NOTE: every signal written in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    rd1_d = read_path(ReadRegister1);
    rd2_d = read_path(ReadRegister2);
  end

  if (READ_LATENCY == 0) begin : g_comb_read
    assign ReadData1 = rd1_d;
    assign ReadData2 = rd2_d;
  end else if (READ_LATENCY == 1) begin : g_reg_read
    logic [WIDTH-1:0] rd1_q;
    logic [WIDTH-1:0] rd2_q;

    // NOTE: state updates use <= so all flops sample the same pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        rd1_q <= '0;
        rd2_q <= '0;
      end else begin
        rd1_q <= rd1_d;
        rd2_q <= rd2_d;
      end
    end

    assign ReadData1 = rd1_q;
    assign ReadData2 = rd2_q;
  end else begin : g_bad_latency
    $error("regfile_decoded: READ_LATENCY must be 0 or 1");
  end

endmodule

// File: tb/tb_regfile_decoded.sv
// Directed bench for regfile_decoded: default, plain-storage/no-bypass,
// registered-read and narrow 8x8 configurations driven side by side.
module tb_regfile_decoded;

  logic        Clk;
  logic        Reset_n;
  logic        reg_write;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;

  logic [31:0] dut_rd1, dut_rd2, dut_we;
  logic [31:0] nz_rd1, nz_rd2, nz_we;
  logic [31:0] rl_rd1, rl_rd2, rl_we;

  logic        s_reg_write;
  logic [2:0]  s_wr_addr;
  logic [7:0]  s_wr_data;
  logic [2:0]  s_rd_addr1;
  logic [2:0]  s_rd_addr2;
  logic [7:0]  s_rd1, s_rd2, s_we;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_decoded u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .RegWrite(reg_write), .WriteRegister(wr_addr),
    .WriteData(wr_data), .ReadRegister1(rd_addr1), .ReadRegister2(rd_addr2),
    .ReadData1(dut_rd1), .ReadData2(dut_rd2), .WriteEnable(dut_we)
  );

  regfile_decoded #(.ZERO_REG(0), .BYPASS(0)) u_nz (
    .Clk(Clk), .Reset_n(Reset_n), .RegWrite(reg_write), .WriteRegister(wr_addr),
    .WriteData(wr_data), .ReadRegister1(rd_addr1), .ReadRegister2(rd_addr2),
    .ReadData1(nz_rd1), .ReadData2(nz_rd2), .WriteEnable(nz_we)
  );

  regfile_decoded #(.READ_LATENCY(1)) u_rl (
    .Clk(Clk), .Reset_n(Reset_n), .RegWrite(reg_write), .WriteRegister(wr_addr),
    .WriteData(wr_data), .ReadRegister1(rd_addr1), .ReadRegister2(rd_addr2),
    .ReadData1(rl_rd1), .ReadData2(rl_rd2), .WriteEnable(rl_we)
  );

  regfile_decoded #(.WIDTH(8), .ADDR_BITS(3)) u_small (
    .Clk(Clk), .Reset_n(Reset_n), .RegWrite(s_reg_write), .WriteRegister(s_wr_addr),
    .WriteData(s_wr_data), .ReadRegister1(s_rd_addr1), .ReadRegister2(s_rd_addr2),
    .ReadData1(s_rd1), .ReadData2(s_rd2), .WriteEnable(s_we)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, well away from it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    reg_write = 1'b1;
    wr_addr   = a;
    wr_data   = d;
    tick();
    reg_write = 1'b0;
  endtask

  initial begin
    Reset_n     = 1'b0;
    reg_write   = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    rd_addr1    = 5'd5;
    rd_addr2    = 5'd9;
    s_reg_write = 1'b0;
    s_wr_addr   = '0;
    s_wr_data   = '0;
    s_rd_addr1  = '0;
    s_rd_addr2  = '0;
    #12;

    check("reset_rd1",    dut_rd1, 32'h0);
    check("reset_nz_rd2", nz_rd2,  32'h0);
    check("reset_rl_rd1", rl_rd1,  32'h0);
    check("reset_we",     dut_we,  32'h0);

    Reset_n = 1'b1;
    write_reg(5'd5,  32'h0000_00A5);
    write_reg(5'd3,  32'h0000_0011);
    write_reg(5'd9,  32'hCAFE_F00D);
    write_reg(5'd31, 32'hFFFF_FFFF);

    rd_addr1 = 5'd9;
    rd_addr2 = 5'd31;
    #1;
    check("read_r9",     dut_rd1, 32'hCAFE_F00D);
    check("read_r31",    dut_rd2, 32'hFFFF_FFFF);
    check("nz_read_r31", nz_rd2,  32'hFFFF_FFFF);
    tick();
    check("rl_r9_after_edge", rl_rd1, 32'hCAFE_F00D);

    // Registered read: new address must not show until the next edge.
    rd_addr1 = 5'd5;
    #1;
    check("rl_hold_before_edge", rl_rd1,  32'hCAFE_F00D);
    check("comb_r5",             dut_rd1, 32'h0000_00A5);
    tick();
    check("rl_r5_after_edge", rl_rd1, 32'h0000_00A5);

    // Mid-cycle reset: everything clears without a clock edge.
    Reset_n = 1'b0;
    #1;
    check("rl_reset_async", rl_rd1, 32'h0);
    check("rl_reset_async2", rl_rd2, 32'h0);
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a);
      rd_addr2 = 5'(31 - a);
      #1;
      check($sformatf("reset_sweep_rd1_%0d", a), dut_rd1, 32'h0);
      check($sformatf("reset_sweep_nz_%0d", a),  nz_rd2,  32'h0);
    end

    // Write attempted while held in reset is lost.
    reg_write = 1'b1;
    wr_addr   = 5'd10;
    wr_data   = 32'h0000_0055;
    tick();
    Reset_n   = 1'b1;
    reg_write = 1'b0;
    rd_addr1  = 5'd10;
    #1;
    check("write_blocked_in_reset", dut_rd1, 32'h0);

    // First write after release, with decoded enable visible during the cycle.
    reg_write = 1'b1;
    wr_addr   = 5'd7;
    wr_data   = 32'hDEAD_BEEF;
    #1;
    check("we_r7", dut_we, 32'h0000_0080);
    tick();
    reg_write = 1'b0;
    rd_addr1  = 5'd7;
    #1;
    check("read_r7", dut_rd1, 32'hDEAD_BEEF);

    // Zero register: hardwired in u_dut, ordinary storage in u_nz.
    reg_write = 1'b1;
    wr_addr   = 5'd0;
    wr_data   = 32'h1234_5678;
    rd_addr1  = 5'd0;
    #1;
    check("we_r0",          dut_we,  32'h0000_0001);
    check("zero_same_cycle", dut_rd1, 32'h0);
    check("nz_r0_old",       nz_rd1,  32'h0);
    tick();
    reg_write = 1'b0;
    #1;
    check("zero_after_edge", dut_rd1, 32'h0);
    check("nz_r0_stored",    nz_rd1,  32'h1234_5678);
    check("rl_zero_reg",     rl_rd1,  32'h0);
    tick();
    check("zero_later", dut_rd1, 32'h0);

    // Bypass on both ports versus stored-value read.
    write_reg(5'd3, 32'h0000_0011);
    reg_write = 1'b1;
    wr_addr   = 5'd3;
    wr_data   = 32'h0000_0022;
    rd_addr1  = 5'd3;
    rd_addr2  = 5'd3;
    #1;
    check("byp_rd1",    dut_rd1, 32'h0000_0022);
    check("byp_rd2",    dut_rd2, 32'h0000_0022);
    check("nobyp_rd1",  nz_rd1,  32'h0000_0011);
    check("nobyp_rd2",  nz_rd2,  32'h0000_0011);
    tick();
    reg_write = 1'b0;
    #1;
    check("nobyp_next_rd1", nz_rd1, 32'h0000_0022);
    check("nobyp_next_rd2", nz_rd2, 32'h0000_0022);
    check("rl_byp_reg",     rl_rd1, 32'h0000_0022);

    // Decoder sweep on the 32-deep instance.
    wr_data = 32'h0;
    for (int a = 0; a < 32; a++) begin
      logic [31:0] exp_we;
      exp_we    = 32'h1 << a;
      reg_write = 1'b1;
      wr_addr   = 5'(a);
      #1;
      check($sformatf("dec_we_%0d", a), dut_we, exp_we);
      check($sformatf("dec_pop_%0d", a), 32'($countones(dut_we)), 32'd1);
      reg_write = 1'b0;
      #1;
      check($sformatf("dec_off_%0d", a), dut_we, 32'h0);
    end
    tick();

    // Narrow instance: k*17 into r1..r7.
    for (int k = 1; k < 8; k++) begin
      s_reg_write = 1'b1;
      s_wr_addr   = 3'(k);
      s_wr_data   = 8'(k * 17);
      tick();
    end
    s_reg_write = 1'b0;
    for (int k = 1; k < 8; k++) begin
      s_rd_addr1 = 3'(k);
      s_rd_addr2 = 3'(8 - k);
      #1;
      check($sformatf("small_rd1_r%0d", k), 32'(s_rd1), 32'(k * 17));
      check($sformatf("small_rd2_r%0d", 8 - k), 32'(s_rd2), 32'((8 - k) * 17));
    end

    s_reg_write = 1'b0;
    s_wr_addr   = 3'd4;
    s_wr_data   = 8'hEE;
    #1;
    check("small_we_idle", 32'(s_we), 32'h0);
    tick();
    s_rd_addr1 = 3'd4;
    #1;
    check("small_r4_unchanged", 32'(s_rd1), 32'd68);

    for (int a = 0; a < 8; a++) begin
      logic [7:0] exp_swe;
      exp_swe     = 8'h1 << a;
      s_reg_write = 1'b1;
      s_wr_addr   = 3'(a);
      #1;
      check($sformatf("small_dec_%0d", a), 32'(s_we), 32'(exp_swe));
    end
    s_reg_write = 1'b0;
    #1;
    check("small_dec_off", 32'(s_we), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
